// File: rtl/ll_pkg.sv
// Shared types and defaults for the linked-list page returner.
package ll_pkg;

  localparam int unsigned LpszDef  = 8;
  localparam int unsigned PagesDef = 256;
  localparam int unsigned CntszDef = 8;

  typedef logic [LpszDef-1:0] page_t;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLink  = 2'd1,
    StLwait = 2'd2,
    StEmit  = 2'd3
  } state_e;

endpackage

// File: rtl/ll_ret_fifo.sv
// Two-entry in-order FIFO holding pages waiting to be handed back to the manager.
module ll_ret_fifo #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] head_o
);

  logic [Width-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       cnt_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign head_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Storage, pointers and occupancy; cleared contents keep head_o at 0 after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

endmodule

// File: rtl/ll_page_returner.sv
// Walks a page chain from a descriptor, presents each page to the reader, then
// queues it for return to the page manager. A page's link is always read before
// the page is pushed for return, so the manager may reuse the link at once.
module ll_page_returner
  import ll_pkg::*;
#(
  parameter int unsigned Lpsz  = LpszDef,
  parameter int unsigned Pages = PagesDef,
  parameter int unsigned Cntsz = CntszDef
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            d_srdy_i,
  output logic            d_drdy_o,
  input  logic [Lpsz-1:0] d_head_i,
  input  logic [Cntsz-1:0] d_count_i,
  output logic            lr_srdy_o,
  input  logic            lr_drdy_i,
  output logic [Lpsz-1:0] lr_addr_o,
  input  logic            lrsp_srdy_i,
  input  logic [Lpsz-1:0] lrsp_data_i,
  output logic            pg_srdy_o,
  input  logic            pg_drdy_i,
  output logic [Lpsz-1:0] pg_page_o,
  output logic            pg_last_o,
  output logic            lprt_srdy_o,
  input  logic            lprt_drdy_i,
  output logic [Lpsz-1:0] lprt_page_o,
  output logic            busy_o,
  output logic            done_o
);

  if (Pages > (1 << Lpsz)) begin : g_cfg_err
    $error("Pages does not fit in an Lpsz-bit pointer");
  end

  state_e           state_q, state_d;
  logic [Lpsz-1:0]  cur_q, cur_d;
  logic [Lpsz-1:0]  nxt_q, nxt_d;
  logic [Cntsz-1:0] rem_q, rem_d, rem_dec;
  logic             done_q, done_d;
  logic             d_drdy_q, lr_srdy_q, emit_q;
  logic             fifo_full, fifo_empty;
  logic             pg_hs, lprt_hs;

  assign pg_srdy_o = emit_q & ~fifo_full;
  assign pg_hs     = pg_srdy_o & pg_drdy_i;
  assign lprt_hs   = lprt_srdy_o & lprt_drdy_i;
  assign rem_dec   = rem_q - Cntsz'(1);

  // Next-state: descriptor accept, link read, link response, page emit.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    nxt_d   = nxt_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (d_srdy_i && d_drdy_q) begin
          cur_d = d_head_i;
          rem_d = d_count_i;
          if (d_count_i == '0) begin
            done_d = 1'b1;
          end else if (d_count_i == Cntsz'(1)) begin
            state_d = StEmit;
          end else begin
            state_d = StLink;
          end
        end
      end
      StLink: begin
        if (lr_srdy_q && lr_drdy_i) state_d = StLwait;
      end
      StLwait: begin
        if (lrsp_srdy_i) begin
          nxt_d   = lrsp_data_i;
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (pg_hs) begin
          rem_d = rem_dec;
          cur_d = nxt_q;
          if (rem_dec == '0) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else if (rem_dec == Cntsz'(1)) begin
            // Last page: its link is never needed.
            state_d = StEmit;
          end else begin
            state_d = StLink;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, datapath and registered handshake/pulse outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cur_q     <= '0;
      nxt_q     <= '0;
      rem_q     <= '0;
      done_q    <= 1'b0;
      d_drdy_q  <= 1'b0;
      lr_srdy_q <= 1'b0;
      emit_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      nxt_q     <= nxt_d;
      rem_q     <= rem_d;
      done_q    <= done_d;
      d_drdy_q  <= (state_d == StIdle);
      lr_srdy_q <= (state_d == StLink);
      emit_q    <= (state_d == StEmit);
    end
  end

  ll_ret_fifo #(
    .Width(Lpsz)
  ) u_ret_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (pg_hs),
    .push_data_i(cur_q),
    .pop_i      (lprt_hs),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .head_o     (lprt_page_o)
  );

  assign d_drdy_o    = d_drdy_q;
  assign lr_srdy_o   = lr_srdy_q;
  assign lr_addr_o   = cur_q;
  assign pg_page_o   = cur_q;
  assign pg_last_o   = emit_q & (rem_q == Cntsz'(1));
  assign lprt_srdy_o = ~fifo_empty;
  assign busy_o      = (state_q != StIdle) | ~fifo_empty;
  assign done_o      = done_q;

endmodule
